// File: rtl/adder_err_pkg.sv
// adder_err_pkg: shared definitions for the approximate-adder error accumulator.
//   OP_W_DEF / SUM_W_DEF : default operand and sum widths (16 / 17).
//   state_e              : run-control FSM states.
//   abs_diff()           : unsigned |a - b|, zero-extended 64-bit operands.
//   sat_add()            : w-bit unsigned saturating add; bit 64 of the
//                          result flags that saturation occurred.
package adder_err_pkg;

  localparam int unsigned OP_W_DEF  = 16;
  localparam int unsigned SUM_W_DEF = OP_W_DEF + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Callers zero-extend their SUM_W-bit values and truncate the result.
  function automatic logic [63:0] abs_diff(input logic [63:0] a, input logic [63:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  // Returns {saturated, w-bit clamped sum}; w may be 1..64.
  function automatic logic [64:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                          input int unsigned w);
    logic [64:0] lim;
    logic [64:0] s;
    lim = (65'd1 << w) - 65'd1;
    s   = {1'b0, a} + {1'b0, b};
    if (s > lim) return {1'b1, lim[63:0]};
    return {1'b0, s[63:0]};
  endfunction

endpackage

// File: rtl/adder_err_stage.sv
// adder_err_stage: two-stage exact-sum / error-distance pipeline.
//   clk, rst       : clock, synchronous active-high reset (clears valids and data).
//   valid_i        : beat accepted this cycle.
//   op_a_i, op_b_i : operands given to the approximate adder.
//   approx_sum_i   : approximate adder output (OP_W+1 bits).
//   s1_valid_o     : stage 1 holds a beat.
//   s2_valid_o     : stage 2 holds a beat; ed_o is valid.
//   ed_o           : |exact - approx| of the beat in stage 2.
module adder_err_stage
  import adder_err_pkg::*;
#(
  parameter int unsigned OP_W = OP_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  input  logic [OP_W-1:0] op_a_i,
  input  logic [OP_W-1:0] op_b_i,
  input  logic [OP_W:0]   approx_sum_i,
  output logic            s1_valid_o,
  output logic            s2_valid_o,
  output logic [OP_W:0]   ed_o
);

  localparam int unsigned SUM_W = OP_W + 1;

  logic             v1_q, v1_d;
  logic [SUM_W-1:0] exact_q, exact_d;
  logic [SUM_W-1:0] approx_q, approx_d;
  logic             v2_q, v2_d;
  logic [SUM_W-1:0] ed_q, ed_d;

  always_comb begin
    v1_d     = valid_i;
    exact_d  = exact_q;
    approx_d = approx_q;
    if (valid_i) begin
      exact_d  = {1'b0, op_a_i} + {1'b0, op_b_i};
      approx_d = approx_sum_i;
    end
    v2_d = v1_q;
    ed_d = ed_q;
    if (v1_q) ed_d = SUM_W'(abs_diff(64'(exact_q), 64'(approx_q)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q     <= 1'b0;
      exact_q  <= '0;
      approx_q <= '0;
      v2_q     <= 1'b0;
      ed_q     <= '0;
    end else begin
      v1_q     <= v1_d;
      exact_q  <= exact_d;
      approx_q <= approx_d;
      v2_q     <= v2_d;
      ed_q     <= ed_d;
    end
  end

  assign s1_valid_o = v1_q;
  assign s2_valid_o = v2_q;
  assign ed_o       = ed_q;

endmodule

// File: rtl/adder_err_accum.sv
// adder_err_accum: error-statistics accumulator for a 16+16 -> 17-bit
// approximate adder. Compares each approximate sum with the exact sum and
// accumulates sample count, error count, error-distance sum and maximum over
// a sample budget latched on start.
//   clk, rst         : clock, synchronous active-high reset.
//   start            : pulse; clears statistics and starts a run (IDLE/DONE only).
//   num_samples      : sample budget, latched on start.
//   in_valid/in_ready: beat handshake; in_ready depends on state and count only.
//   op_a, op_b       : operands; approx_sum : approximate adder result.
//   busy             : RUN or DRAIN.   done : DONE, held until start/rst.
//   sample_cnt, err_cnt, ed_sum, ed_max : statistics.
//   ovf              : sticky, ed_sum (or ed_sq_sum) saturated.
// Optional build macro ADDER_ERR_SQ_EN adds output ed_sq_sum[63:0], the
// saturating sum of ed*ed.
module adder_err_accum
  import adder_err_pkg::*;
#(
  parameter int unsigned OP_W  = OP_W_DEF,
  parameter int unsigned CNT_W = 32,
  parameter int unsigned ACC_W = 48
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  op_a,
  input  logic [OP_W-1:0]  op_b,
  input  logic [OP_W:0]    approx_sum,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [ACC_W-1:0] ed_sum,
  output logic [OP_W:0]    ed_max,
  output logic             ovf
`ifdef ADDER_ERR_SQ_EN
  ,
  output logic [63:0]      ed_sq_sum
`endif
);

  localparam int unsigned SUM_W = OP_W + 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] budget_q, budget_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] smp_q, smp_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic [SUM_W-1:0] max_q, max_d;
  logic             ovf_q, ovf_d;
  logic [64:0]      sum_add;
`ifdef ADDER_ERR_SQ_EN
  logic [63:0]      sq_q, sq_d;
  logic [64:0]      sq_add;
`endif

  logic             s1_valid, s2_valid;
  logic [SUM_W-1:0] ed;
  logic             fire;

  assign in_ready = (state_q == RUN) && (acc_q < budget_q);
  assign fire     = in_valid && in_ready;

  adder_err_stage #(.OP_W(OP_W)) u_stage (
    .clk          (clk),
    .rst          (rst),
    .valid_i      (fire),
    .op_a_i       (op_a),
    .op_b_i       (op_b),
    .approx_sum_i (approx_sum),
    .s1_valid_o   (s1_valid),
    .s2_valid_o   (s2_valid),
    .ed_o         (ed)
  );

  always_comb begin
    state_d  = state_q;
    budget_d = budget_q;
    acc_d    = acc_q;
    smp_d    = smp_q;
    err_d    = err_q;
    sum_d    = sum_q;
    max_d    = max_q;
    ovf_d    = ovf_q;
    sum_add  = sat_add(64'(sum_q), 64'(ed), ACC_W);
`ifdef ADDER_ERR_SQ_EN
    sq_d     = sq_q;
    sq_add   = sat_add(sq_q, 64'(ed) * 64'(ed), 64);
`endif

    if (s2_valid) begin
      smp_d = smp_q + CNT_W'(1);
      if (ed != '0) err_d = err_q + CNT_W'(1);
      if (ed > max_q) max_d = ed;
      sum_d = ACC_W'(sum_add[63:0]);
      ovf_d = ovf_q | sum_add[64];
`ifdef ADDER_ERR_SQ_EN
      sq_d  = sq_add[63:0];
      ovf_d = ovf_q | sum_add[64] | sq_add[64];
`endif
    end

    unique case (state_q)
      IDLE, DONE: begin
        // Pipeline is empty here, so a start cleanly overrides any update.
        if (start) begin
          budget_d = num_samples;
          acc_d    = '0;
          smp_d    = '0;
          err_d    = '0;
          sum_d    = '0;
          max_d    = '0;
          ovf_d    = 1'b0;
`ifdef ADDER_ERR_SQ_EN
          sq_d     = '0;
`endif
          state_d  = (num_samples == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (fire) begin
          acc_d = acc_q + CNT_W'(1);
          if (acc_q + CNT_W'(1) == budget_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Leave on the edge that retires the last beat from stage 2, so both
        // stages are empty and the statistics final as DONE is entered.
        if (!s1_valid) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      budget_q <= '0;
      acc_q    <= '0;
      smp_q    <= '0;
      err_q    <= '0;
      sum_q    <= '0;
      max_q    <= '0;
      ovf_q    <= 1'b0;
`ifdef ADDER_ERR_SQ_EN
      sq_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      budget_q <= budget_d;
      acc_q    <= acc_d;
      smp_q    <= smp_d;
      err_q    <= err_d;
      sum_q    <= sum_d;
      max_q    <= max_d;
      ovf_q    <= ovf_d;
`ifdef ADDER_ERR_SQ_EN
      sq_q     <= sq_d;
`endif
    end
  end

  assign busy       = (state_q == RUN) || (state_q == DRAIN);
  assign done       = (state_q == DONE);
  assign sample_cnt = smp_q;
  assign err_cnt    = err_q;
  assign ed_sum     = sum_q;
  assign ed_max     = max_q;
  assign ovf        = ovf_q;
`ifdef ADDER_ERR_SQ_EN
  assign ed_sq_sum  = sq_q;
`endif

endmodule

// File: tb/tb_adder_err_accum.sv
// tb_adder_err_accum: scoreboard bench. Two instances share stimulus: a
// default one (ACC_W=48) and a narrow one (ACC_W=18) for saturation. Each run
// pushes its hand-computed final statistics; a monitor per instance pops and
// compares when the run's result appears (done rising, or done re-entered by
// a zero-budget start).
module tb_adder_err_accum;

  typedef struct {
    logic [63:0] smp;
    logic [63:0] err;
    logic [63:0] sum;
    logic [63:0] mx;
    logic        ov;
    int          dcyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] num_samples = '0;
  logic        in_valid = 1'b0;
  logic [15:0] op_a = '0;
  logic [15:0] op_b = '0;
  logic [16:0] approx_sum = '0;

  logic        rdy_m, busy_m, done_m, ovf_m;
  logic [31:0] smp_m, err_m;
  logic [47:0] sum_m;
  logic [16:0] max_m;
  logic        rdy_n, busy_n, done_n, ovf_n;
  logic [31:0] smp_n, err_n;
  logic [17:0] sum_n;
  logic [16:0] max_n;
`ifdef ADDER_ERR_SQ_EN
  logic [63:0] sq_m, sq_n;
`endif

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int last_acc = 0;
  int st_edge = 0;
  exp_t q_m[$];
  exp_t q_n[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  adder_err_accum #(.OP_W(16), .CNT_W(32), .ACC_W(48)) dut (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(rdy_m), .op_a(op_a), .op_b(op_b),
    .approx_sum(approx_sum), .busy(busy_m), .done(done_m),
    .sample_cnt(smp_m), .err_cnt(err_m), .ed_sum(sum_m), .ed_max(max_m),
    .ovf(ovf_m)
`ifdef ADDER_ERR_SQ_EN
    , .ed_sq_sum(sq_m)
`endif
  );

  adder_err_accum #(.OP_W(16), .CNT_W(32), .ACC_W(18)) dut18 (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(rdy_n), .op_a(op_a), .op_b(op_b),
    .approx_sum(approx_sum), .busy(busy_n), .done(done_n),
    .sample_cnt(smp_n), .err_cnt(err_n), .ed_sum(sum_n), .ed_max(max_n),
    .ovf(ovf_n)
`ifdef ADDER_ERR_SQ_EN
    , .ed_sq_sum(sq_n)
`endif
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic mon_cmp(input string tag, input exp_t e, input logic [63:0] smp,
                         input logic [63:0] err, input logic [63:0] sum,
                         input logic [63:0] mx, input logic ov);
    chk({tag, " sample_cnt"}, smp, e.smp);
    chk({tag, " err_cnt"}, err, e.err);
    chk({tag, " ed_sum"}, sum, e.sum);
    chk({tag, " ed_max"}, mx, e.mx);
    chk({tag, " ovf"}, 64'(ov), 64'(e.ov));
    chk({tag, " done_cycle"}, 64'(cyc), 64'(e.dcyc));
  endtask

  // Monitors: a result is presented when done rises, or when done is
  // re-entered directly from a start taken in DONE (zero budget).
  logic pd_m = 1'b0, sf_m = 1'b0, pd_n = 1'b0, sf_n = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (done_m && (!pd_m || sf_m)) begin
      if (q_m.size() == 0) chk("m48 unexpected result", 64'(smp_m), 64'hDEAD);
      else begin
        e = q_m.pop_front();
        mon_cmp("m48", e, 64'(smp_m), 64'(err_m), 64'(sum_m), 64'(max_m), ovf_m);
      end
    end
    pd_m = done_m;
    sf_m = start && !busy_m && !rst;
  end

  always @(negedge clk) begin
    exp_t e;
    if (done_n && (!pd_n || sf_n)) begin
      if (q_n.size() == 0) chk("m18 unexpected result", 64'(smp_n), 64'hDEAD);
      else begin
        e = q_n.pop_front();
        mon_cmp("m18", e, 64'(smp_n), 64'(err_n), 64'(sum_n), 64'(max_n), ovf_n);
      end
    end
    pd_n = done_n;
    sf_n = start && !busy_n && !rst;
  end

  task automatic push_exp(input logic [63:0] smp, input logic [63:0] err,
                          input logic [63:0] sum48, input logic [63:0] sum18,
                          input logic [63:0] mx, input logic ov18, input int dcyc);
    q_m.push_back('{smp: smp, err: err, sum: sum48, mx: mx, ov: 1'b0, dcyc: dcyc});
    q_n.push_back('{smp: smp, err: err, sum: sum18, mx: mx, ov: ov18, dcyc: dcyc});
  endtask

  task automatic do_start(input logic [31:0] n);
    start = 1'b1;
    num_samples = n;
    @(negedge clk);
    st_edge = cyc + 1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b,
                       input logic [16:0] ap);
    in_valid = v; op_a = a; op_b = b; approx_sum = ap;
    @(negedge clk);
    if (v && rdy_m) last_acc = cyc + 1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_empty();
    int k = 0;
    while ((q_m.size() != 0 || q_n.size() != 0) && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("results drained", 64'(q_m.size() + q_n.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int hits;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset in_ready", 64'(rdy_m), 64'd0);
    chk("reset busy", 64'(busy_m), 64'd0);
    chk("reset done", 64'(done_m), 64'd0);
    chk("reset stats", 64'(smp_m) | 64'(err_m) | 64'(sum_m) | 64'(max_m), 64'd0);
    chk("reset ovf", 64'(ovf_m | ovf_n), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Exact adder model, budget 4, back-to-back
    do_start(32'd4);
    drive(1'b1, 16'hFFFF, 16'h0001, 17'h10000);
    drive(1'b1, 16'h1234, 16'h1111, 17'h02345);
    drive(1'b1, 16'h0000, 16'h0000, 17'h00000);
    drive(1'b1, 16'h8000, 16'h8000, 17'h10000);
    push_exp(4, 0, 0, 0, 0, 1'b0, last_acc + 2);
    wait_empty();

    // Masked approximate model: exact 0x7 / 0x600, approx 0 / 0
    do_start(32'd2);
    drive(1'b1, 16'h0003, 16'h0004, 17'h00000);
    drive(1'b1, 16'h0600, 16'h0000, 17'h00000);
    push_exp(2, 2, 64'h607, 64'h607, 64'h600, 1'b0, last_acc + 2);
    wait_empty();

    // Zero budget from DONE: done next cycle, never ready, stats cleared
    hits = 0;
    in_valid = 1'b1;
    start = 1'b1;
    num_samples = 32'd0;
    @(negedge clk);
    st_edge = cyc + 1;
    if (rdy_m || rdy_n) hits++;
    @(posedge clk); #1;
    start = 1'b0;
    push_exp(0, 0, 0, 0, 0, 1'b0, st_edge);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rdy_m || rdy_n) hits++;
    end
    chk("zero budget in_ready seen", 64'(hits), 64'd0);
    in_valid = 1'b0;
    wait_empty();

    // Budget 3, valid toggling; 4th valid beat must be refused
    do_start(32'd3);
    drive(1'b1, 16'h0001, 16'h0002, 17'h00003);
    drive(1'b0, 16'h0000, 16'h0000, 17'h00000);
    drive(1'b1, 16'h0005, 16'h0005, 17'h00008);
    drive(1'b0, 16'h0000, 16'h0000, 17'h00000);
    drive(1'b1, 16'h0010, 16'h0000, 17'h00013);
    push_exp(3, 2, 5, 5, 3, 1'b0, last_acc + 2);
    in_valid = 1'b1; op_a = 16'hFFFF; op_b = 16'hFFFF; approx_sum = 17'h0;
    @(negedge clk);
    chk("in_ready after budget", 64'(rdy_m), 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_empty();

    // Mid-run reset after the 2nd of 5 beats, then budget 1
    do_start(32'd5);
    drive(1'b1, 16'h0007, 16'h0007, 17'h0000E);
    drive(1'b1, 16'h0001, 16'h0001, 17'h00000);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid-run rst busy/done/ready", {61'd0, busy_m, done_m, rdy_m}, 64'd0);
    chk("mid-run rst stats", 64'(smp_m) | 64'(err_m) | 64'(sum_m) | 64'(max_m), 64'd0);
    @(posedge clk); #1;
    do_start(32'd1);
    drive(1'b1, 16'h0001, 16'h0001, 17'h00000);
    push_exp(1, 1, 2, 2, 2, 1'b0, last_acc + 2);
    wait_empty();

    // Saturation: three beats of ed=0x1FFFF; 18-bit accumulator clamps
    do_start(32'd3);
    for (int i = 0; i < 3; i++) drive(1'b1, 16'h0000, 16'h0000, 17'h1FFFF);
    push_exp(3, 3, 64'h5FFFD, 64'h3FFFF, 64'h1FFFF, 1'b1, last_acc + 2);
    wait_empty();
    repeat (3) @(negedge clk);
    chk("ovf sticky in DONE", 64'(ovf_n), 64'd1);
    chk("ed_sum held in DONE", 64'(sum_n), 64'h3FFFF);
    @(posedge clk); #1;
    do_start(32'd0);
    push_exp(0, 0, 0, 0, 0, 1'b0, st_edge);
    wait_empty();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish (t=%0t)", $time);
    $fatal(1);
  end

endmodule
